// File: rtl/uart_pkg.sv
// Shared UART definitions: frame controller state encoding, default SOF marker,
// and error codes for a status register that aggregates the error pulses.
package uart_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_OUT
    } frame_state_t;

    typedef enum logic [1:0] {
        ERR_CHK,
        ERR_LEN,
        ERR_TIMEOUT,
        ERR_OVERRUN
    } frame_err_t;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN x 8 register array, one write port, one
// combinational read port addressed by index.
module uart_frame_buf #(
    parameter int MAX_LEN = 16,
    parameter int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [0:MAX_LEN-1];

    // Store one payload byte per strobe; contents need no reset since the
    // controller only reads indices written by the current frame.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= wr_data;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART frame controller: parses SOF/LEN/PAYLOAD/CHK frames from uart_rx,
// validates length and XOR checksum (seeded with LEN), aborts on inter-byte
// timeout, buffers the payload and replays it on a valid/ready stream.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int         MAX_LEN       = 16,
    parameter logic [7:0] SOF_BYTE      = SOF_DEFAULT,
    parameter int         TIMEOUT_TICKS = 640
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       frm_valid,
    input  logic       frm_ready,
    output logic [7:0] frm_data,
    output logic       frm_last,
    output logic [7:0] frm_len,
    output logic       busy,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_timeout,
    output logic       err_overrun
);

    localparam int            AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int            TW        = $clog2(TIMEOUT_TICKS);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_TICKS - 1);

    frame_state_t  state;
    logic [7:0]    len_q;
    logic [7:0]    idx_q;
    logic [7:0]    chk_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    rd_data;
    logic          is_last;
    logic          wr_en;

    assign is_last = (idx_q == len_q - 8'd1);
    assign wr_en   = (state == ST_PAYLOAD) && rx_done_tick;

    uart_frame_buf #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (idx_q[AW-1:0]),
        .wr_data (rx_data),
        .rd_idx  (idx_q[AW-1:0]),
        .rd_data (rd_data)
    );

    // Stream fields are qualified by frm_valid so they read 0 when idle.
    assign frm_data = frm_valid ? rd_data : 8'h00;
    assign frm_last = frm_valid && is_last;
    assign frm_len  = frm_valid ? len_q : 8'h00;
    assign busy     = (state != ST_IDLE);

    // Frame FSM with checksum, timeout and replay handshake; error outputs
    // are single-cycle pulses cleared by default every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            chk_q       <= '0;
            tmo_q       <= '0;
            frm_valid   <= 1'b0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_done_tick && rx_data == SOF_BYTE) begin
                        state <= ST_LEN;
                        tmo_q <= '0;
                    end
                end
                ST_LEN, ST_PAYLOAD, ST_CHK: begin
                    // A received byte takes priority over a coincident timeout.
                    if (rx_done_tick) begin
                        tmo_q <= '0;
                        if (state == ST_LEN) begin
                            if (rx_data != 8'h00 && rx_data <= MAX_LEN_B) begin
                                len_q <= rx_data;
                                chk_q <= rx_data;
                                idx_q <= '0;
                                state <= ST_PAYLOAD;
                            end else begin
                                err_len <= 1'b1;
                                state   <= ST_IDLE;
                            end
                        end else if (state == ST_PAYLOAD) begin
                            chk_q <= chk_q ^ rx_data;
                            idx_q <= idx_q + 8'd1;
                            if (is_last)
                                state <= ST_CHK;
                        end else begin
                            if (rx_data == chk_q) begin
                                idx_q     <= '0;
                                frm_valid <= 1'b1;
                                state     <= ST_OUT;
                            end else begin
                                err_chk <= 1'b1;
                                state   <= ST_IDLE;
                            end
                        end
                    end else if (s_tick) begin
                        if (tmo_q == TMO_LAST) begin
                            err_timeout <= 1'b1;
                            tmo_q       <= '0;
                            state       <= ST_IDLE;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    // Bytes arriving while replaying cannot be buffered.
                    if (rx_done_tick)
                        err_overrun <= 1'b1;
                    if (frm_valid && frm_ready) begin
                        if (is_last) begin
                            frm_valid <= 1'b0;
                            idx_q     <= '0;
                            state     <= ST_IDLE;
                        end else begin
                            idx_q <= idx_q + 8'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: stimulus pushes expected stream
// beats and error codes; a negedge monitor pops and compares them.
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       frm_ready = 1'b0;
    logic       frm_valid, frm_last, busy;
    logic [7:0] frm_data, frm_len;
    logic       err_chk, err_len, err_timeout, err_overrun;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] len;
    } beat_t;

    beat_t      exp_beats[$];
    logic [3:0] exp_errs[$];

    localparam logic [3:0] E_CHK = 4'b1000;
    localparam logic [3:0] E_LEN = 4'b0100;
    localparam logic [3:0] E_TMO = 4'b0010;
    localparam logic [3:0] E_OVR = 4'b0001;

    uart_rx_frame_ctrl #(.MAX_LEN(16), .SOF_BYTE(8'hA5), .TIMEOUT_TICKS(640)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .frm_valid    (frm_valid),
        .frm_ready    (frm_ready),
        .frm_data     (frm_data),
        .frm_last     (frm_last),
        .frm_len      (frm_len),
        .busy         (busy),
        .err_chk      (err_chk),
        .err_len      (err_len),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and every error pulse,
    // and checks that stalled beats hold their data.
    initial begin
        logic       stall;
        logic [8:0] held;
        beat_t      b;
        logic [3:0] errs;
        logic [3:0] e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (stall)
                    check("stall_hold", 32'({frm_valid, frm_last, frm_data}), 32'({1'b1, held}));
                if (frm_valid && frm_ready) begin
                    if (exp_beats.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual=%0h required=none", frm_data);
                    end else begin
                        b = exp_beats.pop_front();
                        check("beat", 32'({frm_data, frm_last, frm_len}), 32'({b.data, b.last, b.len}));
                    end
                end
                errs = {err_chk, err_len, err_timeout, err_overrun};
                if (errs != 4'b0000) begin
                    if (exp_errs.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_err actual=%0b required=none", errs);
                    end else begin
                        e = exp_errs.pop_front();
                        check("err_code", 32'(errs), 32'(e));
                    end
                end
                stall = frm_valid && !frm_ready;
                held  = {frm_last, frm_data};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push_beat(input logic [7:0] d, input logic l, input logic [7:0] n);
        beat_t b;
        b.data = d;
        b.last = l;
        b.len  = n;
        exp_beats.push_back(b);
    endtask

    // Wait (bounded) for the controller to go idle, then confirm every
    // expected beat/error was observed.
    task automatic finish_test(input string name);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_idle"}, 32'(busy), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        check({name, "_drained"}, 32'(exp_beats.size() + exp_errs.size()), 32'(0));
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'({busy, frm_valid, frm_last, frm_len, frm_data,
                         err_chk, err_len, err_timeout, err_overrun}), 32'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: checksum covers LEN and payload: 03^11^22^33 = 03
        frm_ready = 1'b1;
        push_beat(8'h11, 1'b0, 8'd3);
        push_beat(8'h22, 1'b0, 8'd3);
        push_beat(8'h33, 1'b1, 8'd3);
        send_byte(8'hA5);
        send_byte(8'h03);
        check("busy_in_frame", 32'(busy), 32'(1));
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h03);
        finish_test("t1_good");

        // 2: bad checksum
        exp_errs.push_back(E_CHK);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h01);
        finish_test("t2_chk");

        // 3: LEN 0 and LEN 17, then a 1-byte frame (chk 01^5A = 5B)
        exp_errs.push_back(E_LEN);
        send_byte(8'hA5);
        send_byte(8'h00);
        finish_test("t3_len0");
        exp_errs.push_back(E_LEN);
        send_byte(8'hA5);
        send_byte(8'h11);
        finish_test("t3_len17");
        push_beat(8'h5A, 1'b1, 8'd1);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h5A);
        send_byte(8'h5B);
        finish_test("t3_after");

        // 4: timeout fires on the 640th tick, not before
        exp_errs.push_back(E_TMO);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        s_tick = 1'b1;
        repeat (639) @(posedge clk);
        #1;
        s_tick = 1'b0;
        @(negedge clk);
        check("t4_busy_639", 32'(busy), 32'(1));
        check("t4_pending_639", 32'(exp_errs.size()), 32'(1));
        @(posedge clk); #1;
        s_tick = 1'b1;
        @(posedge clk); #1;
        s_tick = 1'b0;
        check("t4_idle_640", 32'(busy), 32'(0));
        finish_test("t4_tmo");

        // 5: ready 1/0/0/1 with an overrun byte during the stall (chk 02^C3^3C = FD)
        push_beat(8'hC3, 1'b0, 8'd2);
        push_beat(8'h3C, 1'b1, 8'd2);
        exp_errs.push_back(E_OVR);
        frm_ready = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hC3);
        send_byte(8'h3C);
        rx_data      = 8'hFD;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        check("t5_first_valid", 32'({frm_valid, frm_data}), 32'({1'b1, 8'hC3}));
        @(posedge clk); #1;
        frm_ready    = 1'b0;
        rx_data      = 8'hEE;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        @(posedge clk); #1;
        frm_ready = 1'b1;
        @(posedge clk); #1;
        finish_test("t5_stall");

        // 6a: reset during PAYLOAD
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("t6_rst_payload");
        reset = 1'b0;
        @(posedge clk); #1;

        // 6b: reset during OUT with the sink stalled
        frm_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hC3);
        send_byte(8'h3C);
        send_byte(8'hFD);
        check("t6_out_valid", 32'(frm_valid), 32'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("t6_rst_out");
        reset = 1'b0;
        @(posedge clk); #1;

        // 6c: garbage ignored, then a clean frame
        frm_ready = 1'b1;
        push_beat(8'h5A, 1'b1, 8'd1);
        send_byte(8'h00);
        send_byte(8'hFF);
        check("t6_garbage_idle", 32'(busy), 32'(0));
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h5A);
        send_byte(8'h5B);
        finish_test("t6_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
